// File: rtl/cfg_loader_pkg.sv
// cfg_loader_pkg: shared definitions for the switch-matrix configuration loader.
//   state_t             - loader FSM states
//   DEF_NO_CONFIG_BITS  - default configuration chain length
//   DEF_WORD_W          - default input word width
package cfg_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_LATCH = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int DEF_NO_CONFIG_BITS = 64;
  localparam int DEF_WORD_W         = 32;

endpackage

// File: rtl/cfg_word_serializer.sv
// cfg_word_serializer: holds one configuration word and presents it one bit
// per shift, LSB first, for a programmable number of bits.
//   CLK, RST   - clock, asynchronous active-high reset
//   load       - capture word_data and load_bits
//   load_bits  - number of bits of this word to present (1..WORD_W)
//   word_data  - word to serialize
//   shift      - advance to the next bit
//   bit_out    - current bit
//   last_bit   - current bit is the last one of this word
module cfg_word_serializer
  import cfg_loader_pkg::*;
#(
  parameter int  WORD_W = DEF_WORD_W,
  localparam int BC_W   = $clog2(WORD_W + 1)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              load,
  input  logic [BC_W-1:0]   load_bits,
  input  logic [WORD_W-1:0] word_data,
  input  logic              shift,
  output logic              bit_out,
  output logic              last_bit
);

  logic [WORD_W-1:0] word_reg;
  logic [BC_W-1:0]   bits_left;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      word_reg  <= '0;
      bits_left <= '0;
    end else if (load) begin
      word_reg  <= word_data;
      bits_left <= load_bits;
    end else if (shift && (bits_left != '0)) begin
      word_reg  <= word_reg >> 1;
      bits_left <= bits_left - BC_W'(1);
    end
  end

  // Bits above load_bits are never presented, which drops the unused
  // upper part of a final partial word.
  assign bit_out  = word_reg[0];
  assign last_bit = (bits_left == BC_W'(1));

endmodule

// File: rtl/switch_matrix_config_loader.sv
// switch_matrix_config_loader: accepts configuration words over a valid/ready
// handshake and shifts NO_CONFIG_BITS bits, LSB first, into a switch-matrix
// configuration chain, then pulses conf_latch to commit it.
//   CLK, RST              - clock, asynchronous active-high reset
//   start, abort          - begin a load from IDLE / cancel a load in progress
//   word_data, word_valid, word_ready - input word handshake
//   conf_out, conf_shift  - serial bit and shift enable into the chain head
//   conf_latch            - one-cycle commit pulse
//   busy, done            - load in progress / one-cycle completion pulse
// Optional (CONFIG_READBACK_EN defined):
//   conf_in               - chain tail, sampled on every conf_shift cycle
//   rb_data, rb_valid     - readback word, zero-padded on the MSB side
//
// state  | meaning
// IDLE   | waiting for start
// LOAD   | word_ready high, waiting for a word
// SHIFT  | one chain bit per cycle from the current word
// LATCH  | conf_latch pulse
// DONE   | done pulse, back to IDLE
module switch_matrix_config_loader
  import cfg_loader_pkg::*;
#(
  parameter int NO_CONFIG_BITS = DEF_NO_CONFIG_BITS,
  parameter int WORD_W         = DEF_WORD_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              conf_out,
  output logic              conf_shift,
  output logic              conf_latch,
  output logic              busy,
  output logic              done
`ifdef CONFIG_READBACK_EN
  ,
  input  logic              conf_in,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid
`endif
);

  localparam int CNT_W = $clog2(NO_CONFIG_BITS + 1);
  localparam int BC_W  = $clog2(WORD_W + 1);

  state_t            state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [CNT_W-1:0]  bit_cnt_nxt;
  logic [CNT_W-1:0]  remaining;
  logic [BC_W-1:0]   load_bits;
  logic              ser_load;
  logic              ser_bit;
  logic              ser_last;

  assign bit_cnt_nxt = bit_cnt + CNT_W'(1);
  assign remaining   = CNT_W'(NO_CONFIG_BITS) - bit_cnt;

  // Each word carries min(WORD_W, remaining) bits.
  always_comb begin
    load_bits = BC_W'(WORD_W);
    if (int'(remaining) < WORD_W) load_bits = BC_W'(remaining);
  end

  assign ser_load = (state == ST_LOAD) && word_valid && !abort;

  cfg_word_serializer #(.WORD_W(WORD_W)) u_serializer (
    .CLK       (CLK),
    .RST       (RST),
    .load      (ser_load),
    .load_bits (load_bits),
    .word_data (word_data),
    .shift     (conf_shift),
    .bit_out   (ser_bit),
    .last_bit  (ser_last)
  );

  assign conf_out = conf_shift & ser_bit;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      word_ready <= 1'b0;
      conf_shift <= 1'b0;
      conf_latch <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      conf_latch <= 1'b0;
      done       <= 1'b0;
      if (abort && (state != ST_IDLE)) begin
        // Chain contents are left as they are; only the sequence stops.
        state      <= ST_IDLE;
        word_ready <= 1'b0;
        conf_shift <= 1'b0;
        busy       <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              state      <= ST_LOAD;
              bit_cnt    <= '0;
              word_ready <= 1'b1;
              busy       <= 1'b1;
            end
          end
          ST_LOAD: begin
            if (word_valid) begin
              state      <= ST_SHIFT;
              word_ready <= 1'b0;
              conf_shift <= 1'b1;
            end
          end
          ST_SHIFT: begin
            bit_cnt <= bit_cnt_nxt;
            if (ser_last) begin
              conf_shift <= 1'b0;
              if (bit_cnt_nxt == CNT_W'(NO_CONFIG_BITS)) begin
                state      <= ST_LATCH;
                conf_latch <= 1'b1;
              end else begin
                state      <= ST_LOAD;
                word_ready <= 1'b1;
              end
            end
          end
          ST_LATCH: begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
          ST_DONE: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state      <= ST_IDLE;
            word_ready <= 1'b0;
            conf_shift <= 1'b0;
            busy       <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef CONFIG_READBACK_EN
  localparam int IDX_W = $clog2(WORD_W);

  logic [WORD_W-1:0] rb_sr;
  logic [IDX_W-1:0]  rb_idx;

  // Readback groups line up with input words, so a group closes on the
  // serializer's last bit; a short final word yields a zero-padded group.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rb_sr    <= '0;
      rb_idx   <= '0;
      rb_data  <= '0;
      rb_valid <= 1'b0;
    end else begin
      rb_valid <= 1'b0;
      if (state == ST_IDLE) begin
        rb_sr  <= '0;
        rb_idx <= '0;
      end else if (conf_shift) begin
        if (ser_last) begin
          rb_data  <= rb_sr | (WORD_W'(conf_in) << rb_idx);
          rb_valid <= 1'b1;
          rb_sr    <= '0;
          rb_idx   <= '0;
        end else begin
          rb_sr[rb_idx] <= conf_in;
          rb_idx        <= rb_idx + IDX_W'(1);
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_switch_matrix_config_loader.sv
// Testbench for switch_matrix_config_loader: instance A (64-bit chain) and
// instance B (40-bit chain), both with 32-bit words, driven by one stimulus
// set selected by sel.
module tb_switch_matrix_config_loader;

  logic        CLK = 1'b0;
  logic        RST;
  logic        drv_start, drv_abort, drv_valid;
  logic [31:0] drv_data;
  logic        sel;

  logic a_start, a_abort, a_valid, a_ready, a_out, a_shift, a_latch, a_busy, a_done;
  logic b_start, b_abort, b_valid, b_ready, b_out, b_shift, b_latch, b_busy, b_done;
  logic obs_ready, obs_out, obs_shift, obs_latch, obs_busy, obs_done;

  int checks = 0;
  int errors = 0;

  logic [63:0] cap;
  int          nbits, latch_cnt, done_cnt, latch_at, done_at, load_w1, gap_bad;
  logic        timed_out;
  logic [5:0]  ev;

  always #5 CLK = ~CLK;

  assign a_start = drv_start & ~sel;
  assign a_abort = drv_abort & ~sel;
  assign a_valid = drv_valid & ~sel;
  assign b_start = drv_start & sel;
  assign b_abort = drv_abort & sel;
  assign b_valid = drv_valid & sel;

  assign obs_ready = sel ? b_ready : a_ready;
  assign obs_out   = sel ? b_out   : a_out;
  assign obs_shift = sel ? b_shift : a_shift;
  assign obs_latch = sel ? b_latch : a_latch;
  assign obs_busy  = sel ? b_busy  : a_busy;
  assign obs_done  = sel ? b_done  : a_done;

`ifdef CONFIG_READBACK_EN
  logic [63:0] chain;
  logic [31:0] a_rb_data, b_rb_data;
  logic        a_rb_valid, b_rb_valid;
  logic [31:0] rb_q[$];

  always @(posedge CLK or posedge RST)
    if (RST) chain <= '0;
    else if (a_shift) chain <= {chain[62:0], a_out};

  always @(negedge CLK)
    if (a_rb_valid) rb_q.push_back(a_rb_data);
`endif

  switch_matrix_config_loader #(.NO_CONFIG_BITS(64), .WORD_W(32)) dut_a (
    .CLK(CLK), .RST(RST), .start(a_start), .abort(a_abort),
    .word_data(drv_data), .word_valid(a_valid), .word_ready(a_ready),
    .conf_out(a_out), .conf_shift(a_shift), .conf_latch(a_latch),
    .busy(a_busy), .done(a_done)
`ifdef CONFIG_READBACK_EN
    , .conf_in(chain[63]), .rb_data(a_rb_data), .rb_valid(a_rb_valid)
`endif
  );

  switch_matrix_config_loader #(.NO_CONFIG_BITS(40), .WORD_W(32)) dut_b (
    .CLK(CLK), .RST(RST), .start(b_start), .abort(b_abort),
    .word_data(drv_data), .word_valid(b_valid), .word_ready(b_ready),
    .conf_out(b_out), .conf_shift(b_shift), .conf_latch(b_latch),
    .busy(b_busy), .done(b_done)
`ifdef CONFIG_READBACK_EN
    , .conf_in(1'b0), .rb_data(b_rb_data), .rb_valid(b_rb_valid)
`endif
  );

  // Drives one two-word load on the selected instance and records what it saw.
  // abort_at / rst_at >= 0 fire once that many shift bits have been observed.
  task automatic run_load(input logic [31:0] w0, input logic [31:0] w1, input int gap,
                          input bit hold_start, input int abort_at, input int rst_at);
    int cyc, widx, wait_cnt;
    bit fin;
    cap = '0; nbits = 0; latch_cnt = 0; done_cnt = 0; latch_at = -1; done_at = -1;
    load_w1 = 0; gap_bad = 0; timed_out = 1'b0; ev = '1;
    cyc = 0; widx = 0; wait_cnt = 0; fin = 1'b0;
    @(negedge CLK);
    drv_start = 1'b1;
    while (!fin) begin
      @(negedge CLK);
      cyc++;
      if (obs_shift && nbits < 64) begin cap[nbits] = obs_out; nbits++; end
      if (obs_latch) begin latch_cnt++; latch_at = cyc; end
      if (obs_done) begin done_cnt++; done_at = cyc; fin = 1'b1; end
      if (obs_ready && widx == 1) begin
        load_w1++;
        if (obs_shift || !obs_busy) gap_bad++;
      end
      if (!hold_start || fin) drv_start = 1'b0;
      drv_valid = 1'b0;
      if (obs_ready && widx < 2) begin
        if (widx == 1 && wait_cnt < gap) wait_cnt++;
        else begin
          drv_valid = 1'b1;
          drv_data  = (widx == 0) ? w0 : w1;
          widx++;
        end
      end
      if (abort_at >= 0 && obs_shift && nbits == abort_at) begin
        drv_abort = 1'b1;
        @(negedge CLK);
        drv_abort = 1'b0;
        ev  = {obs_busy, obs_ready, obs_shift, obs_out, obs_latch, obs_done};
        fin = 1'b1;
      end else if (rst_at >= 0 && obs_shift && nbits == rst_at) begin
        RST = 1'b1;
        #1;
        ev = {obs_busy, obs_ready, obs_shift, obs_out, obs_latch, obs_done};
        @(negedge CLK);
        RST = 1'b0;
        fin = 1'b1;
      end
      if (cyc > 400) begin timed_out = 1'b1; fin = 1'b1; end
    end
    if (abort_at >= 0 || rst_at >= 0)
      repeat (5) begin
        @(negedge CLK);
        if (obs_latch) latch_cnt++;
        if (obs_done) done_cnt++;
      end
    drv_start = 1'b0;
    drv_valid = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; sel = 1'b0;
    drv_start = 1'b0; drv_abort = 1'b0; drv_valid = 1'b0; drv_data = '0;
    #12;
    checks++;
    if ({a_busy, a_ready, a_shift, a_out, a_latch, a_done} !== 6'b0) begin
      errors++;
      $display("FAIL reset_a got %b want 000000", {a_busy, a_ready, a_shift, a_out, a_latch, a_done});
    end
    checks++;
    if ({b_busy, b_ready, b_shift, b_out, b_latch, b_done} !== 6'b0) begin
      errors++;
      $display("FAIL reset_b got %b want 000000", {b_busy, b_ready, b_shift, b_out, b_latch, b_done});
    end
    @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    checks++;
    if ({a_busy, a_ready, a_shift, a_latch, a_done} !== 5'b0) begin
      errors++;
      $display("FAIL idle_after_reset got %b want 00000", {a_busy, a_ready, a_shift, a_latch, a_done});
    end
  endtask

  task automatic test_basic();
    sel = 1'b0;
    run_load(32'h0F0F0F0F, 32'hA5A5A5A5, 0, 1'b0, -1, -1);
    checks++;
    if (timed_out !== 1'b0) begin errors++; $display("FAIL basic_timeout got %b want 0", timed_out); end
    checks++;
    if (nbits != 64) begin errors++; $display("FAIL basic_nbits got %0d want 64", nbits); end
    checks++;
    if (cap !== 64'hA5A5A5A5_0F0F0F0F) begin
      errors++; $display("FAIL basic_bits got %h want a5a5a5a50f0f0f0f", cap);
    end
    checks++;
    if (latch_cnt != 1 || done_cnt != 1) begin
      errors++; $display("FAIL basic_pulses got latch %0d done %0d want 1 1", latch_cnt, done_cnt);
    end
    checks++;
    if (latch_at != 67 || done_at != 68) begin
      errors++; $display("FAIL basic_latency got latch %0d done %0d want 67 68", latch_at, done_at);
    end
    @(negedge CLK);
    checks++;
    if ({obs_busy, obs_done, obs_latch} !== 3'b0) begin
      errors++; $display("FAIL basic_idle got %b want 000", {obs_busy, obs_done, obs_latch});
    end
  endtask

  task automatic test_partial();
    sel = 1'b1;
    run_load(32'hFFFFFFFF, 32'h000012AB, 0, 1'b0, -1, -1);
    checks++;
    if (nbits != 40 || timed_out !== 1'b0) begin
      errors++; $display("FAIL partial_nbits got %0d (timeout %b) want 40", nbits, timed_out);
    end
    checks++;
    if (cap !== 64'h000000AB_FFFFFFFF) begin
      errors++; $display("FAIL partial_bits got %h want 000000abffffffff", cap);
    end
    checks++;
    if (latch_at != 43 || done_at != 44 || latch_cnt != 1) begin
      errors++; $display("FAIL partial_latency got latch %0d done %0d want 43 44", latch_at, done_at);
    end
    sel = 1'b0;
  endtask

  // start is held high throughout, which must not disturb the load.
  task automatic test_gap();
    sel = 1'b0;
    run_load(32'h0F0F0F0F, 32'hA5A5A5A5, 5, 1'b1, -1, -1);
    checks++;
    if (cap !== 64'hA5A5A5A5_0F0F0F0F || nbits != 64) begin
      errors++; $display("FAIL gap_bits got %h (%0d bits) want a5a5a5a50f0f0f0f", cap, nbits);
    end
    checks++;
    if (load_w1 != 6 || gap_bad != 0) begin
      errors++; $display("FAIL gap_load got %0d cycles %0d bad want 6 0", load_w1, gap_bad);
    end
    checks++;
    if (done_at != 73 || latch_cnt != 1 || done_cnt != 1 || timed_out !== 1'b0) begin
      errors++; $display("FAIL gap_done got done_at %0d latch %0d done %0d want 73 1 1", done_at, latch_cnt, done_cnt);
    end
  endtask

  task automatic test_abort();
    sel = 1'b0;
    run_load(32'h0F0F0F0F, 32'hA5A5A5A5, 0, 1'b0, 20, -1);
    checks++;
    if (nbits != 20 || cap[19:0] !== 20'hF0F0F) begin
      errors++; $display("FAIL abort_bits got %0d bits %h want 20 f0f0f", nbits, cap[19:0]);
    end
    checks++;
    if (ev !== 6'b0) begin errors++; $display("FAIL abort_idle got %b want 000000", ev); end
    checks++;
    if (latch_cnt != 0 || done_cnt != 0) begin
      errors++; $display("FAIL abort_pulses got latch %0d done %0d want 0 0", latch_cnt, done_cnt);
    end
    run_load(32'h3C3C9669, 32'h00FF55AA, 0, 1'b0, -1, -1);
    checks++;
    if (cap !== 64'h00FF55AA_3C3C9669 || done_at != 68 || latch_cnt != 1) begin
      errors++; $display("FAIL abort_reload got %h done_at %0d want 00ff55aa3c3c9669 68", cap, done_at);
    end
  endtask

  task automatic test_reset_mid();
    sel = 1'b0;
    run_load(32'h0F0F0F0F, 32'hA5A5A5A5, 0, 1'b0, -1, 10);
    checks++;
    if (ev !== 6'b0) begin errors++; $display("FAIL rst_async got %b want 000000", ev); end
    checks++;
    if (nbits != 10 || latch_cnt != 0 || done_cnt != 0) begin
      errors++; $display("FAIL rst_partial got %0d bits latch %0d done %0d want 10 0 0", nbits, latch_cnt, done_cnt);
    end
    run_load(32'hDEADBEEF, 32'h13579BDF, 0, 1'b0, -1, -1);
    checks++;
    if (cap !== 64'h13579BDF_DEADBEEF || done_at != 68 || latch_cnt != 1) begin
      errors++; $display("FAIL rst_reload got %h done_at %0d want 13579bdfdeadbeef 68", cap, done_at);
    end
  endtask

`ifdef CONFIG_READBACK_EN
  task automatic test_readback();
    sel = 1'b0;
    rb_q.delete();
    run_load(32'h12345678, 32'hCAFEF00D, 0, 1'b0, -1, -1);
    run_load(32'h12345678, 32'hCAFEF00D, 0, 1'b0, -1, -1);
    checks++;
    if (rb_q.size() != 4) begin
      errors++; $display("FAIL rb_count got %0d want 4", rb_q.size());
    end else begin
      checks++;
      if (rb_q[2] !== 32'h12345678 || rb_q[3] !== 32'hCAFEF00D) begin
        errors++; $display("FAIL rb_words got %h %h want 12345678 cafef00d", rb_q[2], rb_q[3]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_partial();
    test_gap();
    test_abort();
    test_reset_mid();
`ifdef CONFIG_READBACK_EN
    test_readback();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/switch_matrix_config_loader.md
SWITCH_MATRIX_CONFIG_LOADER -- requirements
Module: switch_matrix_config_loader

Interface
REQ-001 SHALL have parameter NO_CONFIG_BITS, default 64: length of the target switch-matrix configuration chain; legal range 1..4096.
REQ-002 SHALL have parameter WORD_W, default 32: width of the input config word; legal range 8..64.
REQ-003 SHALL have one clock; reset is asynchronous and active-high. Ports: CLK input 1, the single clock; RST input 1, the asynchronous active-high reset.
REQ-004 SHALL have port start  input  1: begins a load when the FSM is in IDLE.
REQ-005 SHALL have port abort  input  1: synchronous cancel of any load in progress.
REQ-006 SHALL have port word_data  input  WORD_W: config word; LSB is shifted first.
REQ-007 SHALL have port word_valid  input  1 and port word_ready  output  1: valid/ready handshake; a word transfers on a CLK edge when both are 1.
REQ-008 SHALL have port conf_out  output  1: serial bit into the head of the chain.
REQ-009 SHALL have port conf_shift  output  1: chain shift enable; 1 exactly when conf_out carries a valid bit.
REQ-010 SHALL have port conf_latch  output  1: one-cycle pulse that commits the chain to the configuration latches.
REQ-011 SHALL have ports busy  output  1 and done  output  1.

Function
REQ-012 SHALL implement FSM states IDLE, LOAD, SHIFT, LATCH, DONE.
REQ-013 IDLE: busy=0; on start=1, go to LOAD and clear the bit counter.
REQ-014 LOAD: word_ready=1; on handshake, capture word_data and go to SHIFT; while word_valid=0, hold in LOAD with conf_shift=0.
REQ-015 SHIFT: one bit per cycle, LSB first, conf_shift=1; shift min(WORD_W, remaining) bits; on the final bit go to LATCH if the counter reaches NO_CONFIG_BITS, else go to LOAD.
REQ-016 When NO_CONFIG_BITS is not a multiple of WORD_W, only the low (NO_CONFIG_BITS mod WORD_W) bits of the final word SHALL be shifted; the upper bits are discarded.
REQ-017 LATCH: conf_latch=1 for exactly one cycle, then go to DONE.
REQ-018 DONE: done=1 for exactly one cycle, then go to IDLE.
REQ-019 busy SHALL be 1 in LOAD, SHIFT, LATCH and DONE.
REQ-020 start while busy SHALL be ignored.
REQ-021 abort in any non-IDLE state SHALL force IDLE on the next edge: no conf_latch, no done, partial chain contents left untouched; abort has priority over every transition in the same cycle.
REQ-022 Minimum load latency SHALL be NO_CONFIG_BITS shift cycles + ceil(NO_CONFIG_BITS/WORD_W) LOAD cycles + 2 cycles.
REQ-023 The bit counter SHALL be $clog2(NO_CONFIG_BITS+1) bits wide and SHALL never wrap.

Reset
REQ-024 RST=1 SHALL asynchronously force IDLE with all outputs 0, the counter at 0 and the word register at 0, including in the middle of a load.
REQ-025 The first load after RST deasserts SHALL behave identically to a load from power-up.

Configuration
REQ-026 With CONFIG_READBACK_EN defined: add port conf_in  input  1 (tail of the chain), sampled on every conf_shift cycle into a WORD_W readback register; add port rb_data  output  WORD_W and port rb_valid  output  1, a one-cycle pulse after each WORD_W sampled bits and after the final partial group (zero-padded, MSB side); there is no backpressure; rb_data and rb_valid reset to 0.
REQ-027 Without CONFIG_READBACK_EN: conf_in, rb_data and rb_valid SHALL be absent and no readback logic SHALL exist.

Structure
REQ-028 A shared package cfg_loader_pkg SHALL hold the FSM state enum and the default constants for NO_CONFIG_BITS and WORD_W.
REQ-029 The serializer (word register, shift and per-word count) SHALL be the single sub-module cfg_word_serializer; the FSM and total counter stay in the top module.

Verification
REQ-030 N=64, W=32; words 0x0F0F0F0F then 0xA5A5A5A5 -> conf_out = 1,1,1,1,0,0,0,0,... for 32 cycles, then 1,0,1,0,0,1,0,1,... for 32 cycles; conf_latch pulses once, done pulses on the following cycle.
REQ-031 N=40, W=32; words 0xFFFFFFFF then 0x000012AB -> 40 shift cycles total, the last 8 bits are 0xAB LSB first, and bits [31:8] are never shifted.
REQ-032 N=64, word_valid held low for 5 cycles before the second word -> conf_shift=0 and busy=1 during the gap, with the same output bit sequence as REQ-030.
REQ-033 abort asserted at shift cycle 20 -> IDLE next cycle; conf_latch and done never assert; a new start completes normally.
REQ-034 RST pulsed at shift cycle 10 -> all outputs 0 immediately (asynchronous); after reset release, a fresh load succeeds.
REQ-035 With CONFIG_READBACK_EN, N=64, conf_in looped through a 64-stage model chain, two loads of the same data -> the second load's two rb_data words equal the words from the first load.
